// File: rtl/dac_transmitter_pkg.sv
// Shared audio constants for the DAC serial transmitter.
// Sample width and rate of the stereo audio path.
package dac_transmitter_pkg;
  localparam int SAMPLE_WIDTH = 24;
  localparam int SAMPLE_RATE = 48000;
  localparam int BIT_CLK_HZ = SAMPLE_RATE * 2 * SAMPLE_WIDTH;
endpackage

// File: rtl/dac_transmitter.sv
// I2S transmitter: serialises a stereo sample pair per frame.
// One slot per clk, one-slot data delay, MSB first.
module dac_transmitter
  import dac_transmitter_pkg::*;
#(
  parameter int WIDTH = SAMPLE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] left_data,
  input  logic [WIDTH-1:0] right_data,
  output logic             sclk,
  output logic             lrclk,
  output logic             sd
);

  localparam int FRAME = 2 * WIDTH;
  localparam int CW = $clog2(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] HALF = CW'(WIDTH);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [FRAME-1:0] sr;
  logic             en_q;
  logic             wrap;

  // Next slot index, wrapping at the end of the frame.
  always_comb begin
    wrap = (cnt == LAST);
    cnt_nxt = wrap ? '0 : cnt + 1'b1;
  end

  // Slot counter, word select and the serial shift path.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt   <= LAST;
      lrclk <= 1'b1;
      sd    <= 1'b0;
      sr    <= '0;
    end else begin
      cnt   <= cnt_nxt;
      lrclk <= (cnt_nxt >= HALF);
      sd    <= sr[FRAME-1];
      sr    <= wrap ? {left_data, right_data}
                    : {sr[FRAME-2:0], 1'b0};
    end
  end

  // Registered enable gates the forwarded bit clock.
  always_ff @(posedge clk) begin
    en_q <= enable & ~rst;
  end

  // en_q changes while ~clk falls low, so the gate cannot glitch.
  assign sclk = en_q & ~clk;

endmodule

// File: tb/tb_dac_transmitter.sv
// Directed bench for the I2S DAC transmitter.
// A small frame model supplies the expected lrclk/sd per slot.
`timescale 1ns/1ps
module tb_dac_transmitter;
  localparam int W = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [W-1:0]  left_data;
  logic [W-1:0]  right_data;
  logic          sclk;
  logic          lrclk;
  logic          sd;

  int n_tests = 0;
  int n_fail = 0;

  int          slot;
  logic        idle;
  logic [W-1:0] cur_l;
  logic [W-1:0] cur_r;
  logic        exp_lr;
  logic        exp_sd;
  int          cyc = 0;

  always #5 clk = ~clk;

  dac_transmitter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .left_data  (left_data),
    .right_data (right_data),
    .sclk       (sclk),
    .lrclk      (lrclk),
    .sd         (sd)
  );

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (slot %0d)",
             tag, obs, exp, slot);
    end
  endtask

  // Advance one edge, update the model from the inputs seen
  // at that edge, then compare lrclk and sd.
  task automatic step(input string tag);
    logic old_r0;
    @(posedge clk);
    cyc++;
    old_r0 = idle ? 1'b0 : cur_r[0];
    if (rst || !enable) begin
      slot = W * 2 - 1;
      idle = 1'b1;
      cur_l = '0;
      cur_r = '0;
      exp_lr = 1'b1;
      exp_sd = 1'b0;
    end else begin
      slot = (slot == 2 * W - 1) ? 0 : slot + 1;
      if (slot == 0) begin
        exp_sd = old_r0;
        cur_l = left_data;
        cur_r = right_data;
        idle = 1'b0;
      end else if (slot <= W) begin
        exp_sd = cur_l[W - slot];
      end else begin
        exp_sd = cur_r[2 * W - slot];
      end
      exp_lr = (slot >= W);
    end
    #1;
    chk({tag, "_lr"}, lrclk, exp_lr);
    chk({tag, "_sd"}, sd, exp_sd);
  endtask

  task automatic chk_sclk(input string tag, input logic exp);
    @(negedge clk);
    #1;
    chk(tag, sclk, exp);
  endtask

  initial begin
    int last_fall;
    int high_cnt;
    logic prev_lr;
    slot = 2 * W - 1;
    idle = 1'b1;
    cur_l = '0;
    cur_r = '0;
    rst = 1'b1;
    enable = 1'b1;
    left_data = 24'h800001;
    right_data = 24'h7FFFFE;

    // reset state, rst beats enable
    step("rst0");
    step("rst1");
    chk("rst_lr", lrclk, 1'b1);
    chk("rst_sd", sd, 1'b0);
    chk_sclk("rst_sclk", 1'b0);

    // first frame: 800001 / 7FFFFE
    rst = 1'b0;
    step("f0_s0");
    chk("f0_s0_lr_hand", lrclk, 1'b0);
    chk("f0_s0_sd_hand", sd, 1'b0);
    chk_sclk("run_sclk_hi", 1'b1);
    step("f0_s1");
    chk("f0_s1_hand", sd, 1'b1);
    for (int i = 2; i <= 23; i++) begin
      step("f0_lz");
      chk("f0_left_zero", sd, 1'b0);
    end
    step("f0_s24");
    chk("f0_s24_hand", sd, 1'b1);
    chk("f0_s24_lr", lrclk, 1'b1);
    step("f0_s25");
    chk("f0_s25_hand", sd, 1'b0);
    for (int i = 26; i <= 47; i++) begin
      step("f0_ro");
      chk("f0_right_one", sd, 1'b1);
    end
    step("f1_s0");
    chk("f1_s0_hand", sd, 1'b0);
    chk("f1_s0_lr", lrclk, 1'b0);

    // free run 10 frames: period and duty of lrclk
    last_fall = cyc;
    high_cnt = 0;
    prev_lr = lrclk;
    for (int i = 0; i < 10 * 2 * W; i++) begin
      step("free");
      if (lrclk) high_cnt++;
      if (prev_lr && !lrclk) begin
        n_tests++;
        assert (cyc - last_fall == 2 * W)
        else begin
          n_fail++;
          $error("FAIL lr_period: observed %0d expected %0d",
                 cyc - last_fall, 2 * W);
        end
        chk("fall_on_wrap", slot == 0, 1'b1);
        last_fall = cyc;
      end
      prev_lr = lrclk;
    end
    n_tests++;
    assert (high_cnt == 10 * W)
    else begin
      n_fail++;
      $error("FAIL lr_duty: observed %0d expected %0d",
             high_cnt, 10 * W);
    end

    // change left mid-frame at slot 10
    while (slot != 10) step("to10");
    left_data = 24'h123456;
    step("s11");
    chk("s11_old_left", sd, 1'b0);
    while (slot != 0) step("rest");
    step("n_s1");
    chk("new_left_b23", sd, 1'b0);
    step("n_s2");
    step("n_s3");
    step("n_s4");
    chk("new_left_b20", sd, 1'b1);

    // drop enable in slot 30
    while (slot != 30) step("to30");
    enable = 1'b0;
    step("dis");
    chk("dis_lr", lrclk, 1'b1);
    chk("dis_sd", sd, 1'b0);
    chk_sclk("dis_sclk", 1'b0);
    step("dis2");
    enable = 1'b1;
    step("reen");
    chk("reen_slot0_lr", lrclk, 1'b0);
    chk("reen_slot0_sd", sd, 1'b0);
    chk_sclk("reen_sclk", 1'b1);

    // reset mid-frame with enable held high
    while (slot != 17) step("to17");
    rst = 1'b1;
    left_data = 24'h000000;
    right_data = 24'hFFFFFF;
    step("mrst");
    chk("mrst_lr", lrclk, 1'b1);
    chk("mrst_sd", sd, 1'b0);
    chk_sclk("mrst_sclk", 1'b0);

    // all-zero left, all-ones right
    rst = 1'b0;
    step("z_s0");
    chk("z_s0_sd", sd, 1'b0);
    for (int i = 1; i <= W; i++) begin
      step("zl");
      chk("all_zero_left", sd, 1'b0);
    end
    for (int i = W + 1; i <= 2 * W; i++) begin
      step("or");
      chk("all_ones_right", sd, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_transmitter.md
DAC_TRANSMITTER -- requirements
Module: dac_transmitter

Interface
REQ-001 SHALL have parameter WIDTH, default 24: bits per channel sample; serial frame length is 2*WIDTH.
REQ-002 SHALL have clk  input  1  bit-rate clock, 2*WIDTH*fs (2.304 MHz for 48 kHz, WIDTH=24); the only clock.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have enable  input  1  transmit enable, driven from clock-wizard locked.
REQ-005 SHALL have left_data  input  WIDTH  signed two's-complement left sample.
REQ-006 SHALL have right_data  input  WIDTH  signed two's-complement right sample.
REQ-007 SHALL have sclk  output  1  serial bit clock forwarded to DAC.
REQ-008 SHALL have lrclk  output  1  word select: 0 = left slot, 1 = right slot.
REQ-009 SHALL have sd  output  1  serial data, MSB first.

Function
REQ-010 SHALL use I2S format: frame of 2*WIDTH slots; slots 0..WIDTH-1 lrclk=0, slots WIDTH..2*WIDTH-1 lrclk=1; one slot per clk cycle.
REQ-011 SHALL apply a one-slot I2S delay: left MSB in slot 1, left LSB in slot WIDTH (first right slot), right MSB in slot WIDTH+1, right LSB in slot 0 of the following frame.
REQ-012 SHALL update lrclk and sd only on posedge clk (all outputs except sclk registered).
REQ-013 SHALL drive sclk = ~clk while en_q=1, else constant 0; en_q is a register loaded with (enable & ~rst) on posedge clk, so DAC samples sd on sclk rising edge, mid-slot, glitch-free.
REQ-014 SHALL keep a slot counter 0..2*WIDTH-1, incrementing each enabled cycle and wrapping 2*WIDTH-1 -> 0.
REQ-015 SHALL capture left_data and right_data together in the cycle the counter wraps to slot 0 (lrclk falling); inputs may change at any other time without effect on the current frame.
REQ-016 SHALL produce frame rate f_clk/(2*WIDTH): exactly 48 kHz at 2.304 MHz, WIDTH=24.
REQ-017 SHALL treat samples as raw bit patterns; no sign extension, rounding or saturation.
REQ-018 SHALL, when enable=0 at a posedge, return synchronously to the reset state; when enable rises, the next edge enters slot 0 and starts a new frame with freshly captured data.
REQ-019 SHALL give rst priority over enable when both are active.

Reset
REQ-020 SHALL on rst=1 set counter=2*WIDTH-1, lrclk=1, sd=0, shift register=0, en_q=0 (sclk=0).
REQ-021 SHALL, on the first enabled edge after reset, enter slot 0 (lrclk falls, sd=0 from cleared register) and capture inputs; latency from capture to left MSB on sd is one clk.

Structure
REQ-022 SHALL take SAMPLE_WIDTH (24) and SAMPLE_RATE (48000) from the shared constants package; no typedefs are needed.
REQ-023 SHALL be a single module with no sub-module: slot counter, 2*WIDTH-bit shift register and en_q register.

Verification
REQ-024 Reset then enable=1, left=24'h800001, right=24'h7FFFFE -> slot 0 sd=0; slots 1..24 sd=1,0x22,1; slots 25..48 (slot 0 next) sd=0,1x22,0.
REQ-025 Free-run 10 frames -> lrclk period exactly 48 clk, duty 24/24; lrclk falls on counter wrap.
REQ-026 Change left_data to 24'h123456 in slot 10 -> current frame unchanged; new value appears from slot 1 of next frame.
REQ-027 Deassert enable in slot 30 -> next edge: lrclk=1, sd=0, sclk held 0; reassert -> new frame starts at slot 0.
REQ-028 Assert rst with enable=1 in mid-frame -> reset state of REQ-020 on that edge; rst wins over enable.
REQ-029 All-zero then all-ones samples (24'h000000, 24'hFFFFFF) -> sd constant 0 then 1 over the respective 24-bit windows.
